// File: rtl/spi_flash_reader.sv
// Single-IO SPI flash read initiator: issues 0x03 READ frames (cmd + 24-bit address,
// then 32 data bits) and returns one little-endian word per request.
module spi_flash_reader #(
    parameter int unsigned CLK_DIV = 1,
    parameter bit          WAKE    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    localparam logic [2:0] S_WAKE_SH  = 3'd0;
    localparam logic [2:0] S_WAKE_GAP = 3'd1;
    localparam logic [2:0] S_IDLE     = 3'd2;
    localparam logic [2:0] S_SETUP    = 3'd3;
    localparam logic [2:0] S_SHIFT    = 3'd4;
    localparam logic [2:0] S_HOLD     = 3'd5;
    localparam logic [2:0] S_GAP      = 3'd6;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [6:0] FRAME_BITS = 7'd64;
    localparam logic [6:0] WAKE_BITS  = 7'd8;

    logic [2:0]  r_state;
    logic [7:0]  r_div;
    logic [6:0]  r_bit_cnt;
    logic [31:0] r_tx;
    logic [31:0] r_rx;
    logic        r_sck;
    logic        r_csb;
    logic        r_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;

    logic        w_div_done;
    logic [6:0]  w_bit_cnt_inc;
    logic [31:0] w_rx_next;
    logic [31:0] w_rx_word;
    logic [23:0] w_word_addr;
    logic [31:0] w_tx_next;

    assign w_div_done    = (r_div == DIV_LAST);
    assign w_bit_cnt_inc = (r_bit_cnt == FRAME_BITS) ? r_bit_cnt : r_bit_cnt + 7'd1;
    assign w_rx_next     = {r_rx[30:0], flash_io1};
    assign w_tx_next     = {r_tx[30:0], 1'b0};
    assign w_word_addr   = req_addr & 24'hFF_FFFC;
    // First byte received lands in the top of the shifter; it is the word's LSB.
    assign w_rx_word     = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};

    // Only the command and address are shifted out; the zero fill drives io0 low
    // for the 32 data periods.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every state register uses <= so all of them update from the
            // same pre-edge values, keeping the pins and the FSM in lockstep.
            r_state     <= WAKE ? S_WAKE_SH : S_IDLE;
            r_div       <= '0;
            r_bit_cnt   <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_sck       <= 1'b0;
            r_csb       <= 1'b1;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_WAKE_SH: begin
                    if (r_csb) begin
                        r_csb     <= 1'b0;
                        r_tx      <= {8'hAB, 24'h00_0000};
                        r_div     <= '0;
                        r_bit_cnt <= '0;
                    end else if (!w_div_done) begin
                        r_div <= r_div + 8'd1;
                    end else begin
                        r_div <= '0;
                        if (r_bit_cnt == WAKE_BITS) begin
                            r_csb   <= 1'b1;
                            r_state <= S_WAKE_GAP;
                        end else if (!r_sck) begin
                            r_sck <= 1'b1;
                        end else begin
                            r_sck     <= 1'b0;
                            r_tx      <= w_tx_next;
                            r_bit_cnt <= w_bit_cnt_inc;
                        end
                    end
                end

                S_WAKE_GAP, S_GAP: begin
                    if (!w_div_done) begin
                        r_div <= r_div + 8'd1;
                    end else begin
                        r_div   <= '0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (r_ready && req_valid) begin
                        r_ready   <= 1'b0;
                        r_csb     <= 1'b0;
                        r_tx      <= {8'h03, w_word_addr};
                        r_div     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_SETUP;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end

                S_SETUP: begin
                    if (!w_div_done) begin
                        r_div <= r_div + 8'd1;
                    end else begin
                        r_div   <= '0;
                        r_sck   <= 1'b1;
                        r_rx    <= w_rx_next;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (!w_div_done) begin
                        r_div <= r_div + 8'd1;
                    end else begin
                        r_div <= '0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                            r_rx  <= w_rx_next;
                        end else begin
                            r_sck     <= 1'b0;
                            r_tx      <= w_tx_next;
                            r_bit_cnt <= w_bit_cnt_inc;
                            if (r_bit_cnt == FRAME_BITS - 7'd1) begin
                                r_state <= S_HOLD;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (!w_div_done) begin
                        r_div <= r_div + 8'd1;
                    end else begin
                        r_div       <= '0;
                        r_csb       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_rx_word;
                        r_state     <= S_GAP;
                    end
                end

                default: begin
                    r_csb   <= 1'b1;
                    r_sck   <= 1'b0;
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign flash_csb = r_csb;
    assign flash_clk = r_sck;
    assign flash_io0 = r_tx[31];
    assign busy      = ~r_csb | (r_state == S_WAKE_SH) | (r_state == S_WAKE_GAP);

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=1 with wake, CLK_DIV=3 without)
// each served by a small behavioural READ-command flash model.
module tb_spi_flash_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst       = 2'b11;
    logic [1:0]  req_valid = 2'b00;
    logic [23:0] req_addr [2];
    wire  [1:0]  req_ready, rsp_valid, busy, csb, sck, mosi, miso;
    wire  [31:0] rsp_data [2];
    logic [7:0]  mem [0:511];

    int n_checks = 0;
    int n_pass   = 0;

    spi_flash_reader #(.CLK_DIV(1), .WAKE(1'b1)) u_dut1 (
        .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .busy(busy[0]), .flash_csb(csb[0]), .flash_clk(sck[0]), .flash_io0(mosi[0]),
        .flash_io1(miso[0])
    );

    spi_flash_reader #(.CLK_DIV(3), .WAKE(1'b0)) u_dut3 (
        .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .busy(busy[1]), .flash_csb(csb[1]), .flash_clk(sck[1]), .flash_io0(mosi[1]),
        .flash_io1(miso[1])
    );

    // Flash model: shifts MOSI in on SCK rise, drives data on SCK fall after 32 bits.
    for (genvar g = 0; g < 2; g++) begin : g_fl
        int          f_bits    = 0;
        int          last_bits = 0;
        int          j;
        logic [31:0] f_shift   = '0;
        logic [31:0] f_frame   = '0;
        logic [7:0]  last_byte = '0;
        logic        f_io1     = 1'b0;
        assign miso[g] = f_io1;
        always @(posedge sck[g] or posedge csb[g]) begin
            if (csb[g] === 1'b1) begin
                last_bits = f_bits;
                last_byte = f_shift[7:0];
                f_bits    = 0;
            end else begin
                f_shift = {f_shift[30:0], mosi[g]};
                f_bits++;
                if (f_bits == 32) f_frame = f_shift;
            end
        end
        always @(negedge sck[g]) begin
            if (csb[g] === 1'b0 && f_bits >= 32 && f_bits < 64) begin
                j     = f_bits - 32;
                f_io1 = mem[f_frame[8:0] + 9'(j / 8)][3'(7 - (j % 8))];
            end
        end
    end

    typedef struct {
        int          unit;
        logic [23:0] addr;
        logic [23:0] late_addr;
        bit          change;
        logic [31:0] exp_data;
        logic [31:0] exp_frame;
        int          exp_rsp;
        int          exp_ready;
        int          exp_rise;
        int          exp_half;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] frame_of(input int u);
        return (u == 0) ? g_fl[0].f_frame : g_fl[1].f_frame;
    endfunction

    task automatic wait_ready(input int u, input string name);
        int k;
        k = 0;
        while (!req_ready[u] && k < 2000) begin
            step();
            k++;
        end
        check({name, " ready"}, 32'(req_ready[u]), 32'd1);
    endtask

    // One read; offsets are in cycles after the handshake cycle (k=0).
    task automatic run_read(input int u, input logic [23:0] addr, input bit change,
                            input logic [23:0] late_addr, output logic [31:0] data,
                            output int k_csb, output int k_rise, output int k_rsp,
                            output int k_ready, output int hi_len, output int lo_len,
                            output int width);
        int   k;
        int   n_rise;
        logic prev;
        wait_ready(u, "read");
        req_addr[u]  = addr;
        req_valid[u] = 1'b1;
        k = 0; n_rise = 0; prev = sck[u];
        data = '0; k_csb = -1; k_rise = -1; k_rsp = -1; k_ready = -1;
        hi_len = 0; lo_len = 0; width = 0;
        while (k < 1000 && k_ready < 0) begin
            step();
            k++;
            if (k == 1) begin
                req_valid[u] = 1'b0;
                if (change) req_addr[u] = late_addr;
            end
            if (k_csb < 0 && !csb[u]) k_csb = k;
            if (sck[u] && !prev) begin
                n_rise++;
                if (k_rise < 0) k_rise = k;
            end
            if (n_rise == 1 && sck[u]) hi_len++;
            if (n_rise == 1 && !sck[u]) lo_len++;
            if (rsp_valid[u]) begin
                width++;
                if (k_rsp < 0) begin
                    k_rsp = k;
                    data  = rsp_data[u];
                end
            end
            if (k_rsp >= 0 && req_ready[u]) k_ready = k;
            prev = sck[u];
        end
    endtask

    task automatic back_to_back(input int u, input logic [23:0] a0, input logic [23:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input int exp_apart, input int exp_gap);
        int          k;
        int          hs;
        int          n_rsp;
        int          gap;
        int          rsp_k [2];
        logic [31:0] data [2];
        bit          drop_next;
        wait_ready(u, "b2b");
        req_addr[u]  = a0;
        req_valid[u] = 1'b1;
        k = 0; hs = 0; n_rsp = 0; gap = 0; drop_next = 1'b0;
        rsp_k[0] = -1; rsp_k[1] = -1; data[0] = '0; data[1] = '0;
        while (k < 2000 && n_rsp < 2) begin
            if (req_ready[u] && req_valid[u]) begin
                hs++;
                if (hs == 2) drop_next = 1'b1;
            end
            step();
            k++;
            if (k == 1) req_addr[u] = a1;
            if (drop_next) begin
                req_valid[u] = 1'b0;
                drop_next    = 1'b0;
            end
            if (rsp_valid[u]) begin
                rsp_k[n_rsp] = k;
                data[n_rsp]  = rsp_data[u];
                n_rsp++;
            end
            if (n_rsp == 1 && csb[u]) gap++;
        end
        req_valid[u] = 1'b0;
        check("b2b first data", data[0], d0);
        check("b2b second data", data[1], d1);
        check("b2b rsp spacing", 32'(rsp_k[1] - rsp_k[0]), 32'(exp_apart));
        check("b2b csb high gap", 32'(gap), 32'(exp_gap));
    endtask

    initial begin
        int          k, low, rises, k_rdy, k_fall, pulses;
        int          kc, kr, ks, kd, hl, ll, w;
        logic        prev;
        logic [31:0] d;

        #60_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, low, rises, k_rdy, k_fall, pulses;
        int          kc, kr, ks, kd, hl, ll, w;
        logic        prev;
        logic [31:0] d;

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[0]     = 8'h11; mem[1]     = 8'h22; mem[2]     = 8'h33; mem[3]     = 8'h44;
        mem[4]     = 8'h55; mem[5]     = 8'h66; mem[6]     = 8'h77; mem[7]     = 8'h88;
        mem[8]     = 8'hA5; mem[9]     = 8'h5A; mem[10]    = 8'hFF; mem[11]    = 8'h00;
        mem[16]    = 8'h6F; mem[17]    = 8'h00; mem[18]    = 8'h00; mem[19]    = 8'h0B;
        mem[256]   = 8'hDE; mem[257]   = 8'hAD; mem[258]   = 8'hBE; mem[259]   = 8'hEF;
        mem[508]   = 8'h01; mem[509]   = 8'h80; mem[510]   = 8'h7F; mem[511]   = 8'hFE;
        req_addr[0] = '0;
        req_addr[1] = '0;

        vecs[0] = '{0, 24'h000013, 24'h000000, 1'b0, 32'h0B00006F, 32'h03000010, 130, 131, 2, 1};
        vecs[1] = '{0, 24'h000100, 24'hFFFFFC, 1'b1, 32'hEFBEADDE, 32'h03000100, 130, 131, 2, 1};
        vecs[2] = '{0, 24'h0001FF, 24'h000000, 1'b0, 32'hFE7F8001, 32'h030001FC, 130, 131, 2, 1};
        vecs[3] = '{1, 24'h000005, 24'h000000, 1'b0, 32'h88776655, 32'h03000004, 388, 391, 4, 3};
        vecs[4] = '{1, 24'h00000A, 24'h000000, 1'b0, 32'h00FF5AA5, 32'h03000008, 388, 391, 4, 3};

        // Reset values, one cycle into reset
        step();
        for (int u = 0; u < 2; u++) begin
            check("reset csb", 32'(csb[u]), 32'd1);
            check("reset sck", 32'(sck[u]), 32'd0);
            check("reset io0", 32'(mosi[u]), 32'd0);
            check("reset req_ready", 32'(req_ready[u]), 32'd0);
            check("reset rsp_valid", 32'(rsp_valid[u]), 32'd0);
            check("reset rsp_data", rsp_data[u], 32'd0);
        end
        check("reset busy wake", 32'(busy[0]), 32'd1);
        check("reset busy nowake", 32'(busy[1]), 32'd0);
        for (int i = 0; i < 4; i++) step();

        // Wake sequence after release
        rst = 2'b00;
        k = 0; low = 0; rises = 0; k_rdy = -1; k_fall = -1; pulses = 0; prev = sck[0];
        while (k < 200 && k_rdy < 0) begin
            step();
            k++;
            if (!csb[0]) begin
                low++;
                if (k_fall < 0) k_fall = k;
            end
            if (sck[0] && !prev) rises++;
            prev = sck[0];
            if (rsp_valid[0]) pulses++;
            if (req_ready[0]) k_rdy = k;
        end
        check("wake csb fall", 32'(k_fall), 32'd1);
        check("wake csb low cycles", 32'(low), 32'd17);
        check("wake sck rises", 32'(rises), 32'd8);
        check("wake ready cycle", 32'(k_rdy), 32'd19);
        check("wake rsp pulses", 32'(pulses), 32'd0);
        check("wake bits", 32'(g_fl[0].last_bits), 32'd8);
        check("wake byte", 32'(g_fl[0].last_byte), 32'h000000AB);
        check("idle busy", 32'(busy[0]), 32'd0);

        // Table-driven single reads
        for (int i = 0; i < 5; i++) begin
            run_read(vecs[i].unit, vecs[i].addr, vecs[i].change, vecs[i].late_addr,
                     d, kc, kr, ks, kd, hl, ll, w);
            check($sformatf("v%0d data", i), d, vecs[i].exp_data);
            check($sformatf("v%0d mosi frame", i), frame_of(vecs[i].unit), vecs[i].exp_frame);
            check($sformatf("v%0d csb fall", i), 32'(kc), 32'd1);
            check($sformatf("v%0d first rise", i), 32'(kr), 32'(vecs[i].exp_rise));
            check($sformatf("v%0d sck high len", i), 32'(hl), 32'(vecs[i].exp_half));
            check($sformatf("v%0d sck low len", i), 32'(ll), 32'(vecs[i].exp_half));
            check($sformatf("v%0d rsp cycle", i), 32'(ks), 32'(vecs[i].exp_rsp));
            check($sformatf("v%0d ready cycle", i), 32'(kd), 32'(vecs[i].exp_ready));
            check($sformatf("v%0d rsp width", i), 32'(w), 32'd1);
        end

        // Back-to-back with req_valid held high
        back_to_back(0, 24'h000000, 24'h000004, 32'h44332211, 32'h88776655, 131, 2);
        back_to_back(1, 24'h000008, 24'h000010, 32'h00FF5AA5, 32'h0B00006F, 391, 4);

        // Reset after the 20th SCK rise of a read
        wait_ready(0, "abort");
        req_addr[0]  = 24'h000010;
        req_valid[0] = 1'b1;
        step();
        req_valid[0] = 1'b0;
        k = 0; rises = 0; prev = sck[0];
        while (k < 500 && rises < 20) begin
            step();
            k++;
            if (sck[0] && !prev) rises++;
            prev = sck[0];
        end
        check("abort reached rise 20", 32'(rises), 32'd20);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        check("abort csb", 32'(csb[0]), 32'd1);
        check("abort sck", 32'(sck[0]), 32'd0);
        check("abort rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("abort rsp_data", rsp_data[0], 32'd0);
        k = 0; pulses = 0;
        while (k < 500 && !req_ready[0]) begin
            step();
            k++;
            if (rsp_valid[0]) pulses++;
        end
        check("abort rsp pulses", 32'(pulses), 32'd0);
        check("abort rewake bits", 32'(g_fl[0].last_bits), 32'd8);
        check("abort rewake byte", 32'(g_fl[0].last_byte), 32'h000000AB);
        run_read(0, 24'h000010, 1'b0, 24'h0, d, kc, kr, ks, kd, hl, ll, w);
        check("after abort data", d, 32'h0B00006F);
        check("after abort rsp cycle", 32'(ks), 32'd130);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
